// File: rtl/audio_stream_sched.sv
// audio_stream_sched: sample scheduler between CPU capture/playback registers and the codec FIFOs.
// Define AUDIO_SCHED_LOOPBACK_EN to build mode 11 as capture-to-speaker loopback; otherwise 11 acts as idle.
module audio_stream_sched #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   aud_in_av,
  input  logic [31:0]            codec_left_in,
  input  logic [31:0]            codec_right_in,
  output logic                   rd_En,
  input  logic                   aud_out_allowed,
  output logic                   wr_En,
  output logic [31:0]            codec_left_out,
  output logic [31:0]            codec_right_out,
  input  logic                   cap_rd,
  output logic                   cap_valid,
  output logic [31:0]            cap_left,
  output logic [31:0]            cap_right,
  output logic [$clog2(DEPTH):0] cap_count,
  output logic                   cap_ovf,
  input  logic                   cap_ovf_clr,
  input  logic                   play_wr,
  input  logic [31:0]            play_left,
  input  logic [31:0]            play_right,
  output logic                   play_busy,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] MODE_CAP  = 2'b01;
  localparam logic [1:0] MODE_PLAY = 2'b10;
`ifdef AUDIO_SCHED_LOOPBACK_EN
  localparam logic [1:0] MODE_LOOP = 2'b11;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e          state_q;
  logic [1:0]      run_mode_q;
  logic            mode_active;
  logic            clear_all;
  logic            run_cap;
  logic            run_play;
  logic            run_loop;

  logic [31:0]     fifo_l_q [DEPTH];
  logic [31:0]     fifo_r_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fifo_full;
  logic            cap_pop;
  logic            cap_push;
  logic            push_ok;
  logic            ovf_set;
  logic            ovf_q;

  logic            hold_valid_q;
  logic [31:0]     hold_l_q;
  logic [31:0]     hold_r_q;
  logic            play_load;
  logic            loop_load;

  always_comb begin
    mode_active = (mode == MODE_CAP) || (mode == MODE_PLAY);
`ifdef AUDIO_SCHED_LOOPBACK_EN
    mode_active = mode_active || (mode == MODE_LOOP);
`endif
  end

  assign run_cap  = (state_q == S_RUN) && (run_mode_q == MODE_CAP);
  assign run_play = (state_q == S_RUN) && (run_mode_q == MODE_PLAY);
`ifdef AUDIO_SCHED_LOOPBACK_EN
  assign run_loop = (state_q == S_RUN) && (run_mode_q == MODE_LOOP);
`else
  assign run_loop = 1'b0;
`endif

  // Asserted on every edge whose next state is IDLE, so the IDLE cycle already shows an empty FIFO.
  assign clear_all = (state_q == S_IDLE)
                   || ((state_q == S_FLUSH) && !mode_active)
                   || ((state_q == S_RUN) && (mode != run_mode_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      run_mode_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mode_active) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!mode_active) begin
            state_q <= S_IDLE;
          end else if (!aud_in_av) begin
            state_q    <= S_RUN;
            run_mode_q <= mode;
          end
        end
        S_RUN: begin
          if (mode != run_mode_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Codec handshakes: rd_En pops the codec input head and wr_En pushes the holding register,
  // each only while the codec qualifies it (aud_in_av / aud_out_allowed) in that same cycle.
  assign rd_En = aud_in_av && ((state_q == S_FLUSH) || run_cap || (run_loop && !hold_valid_q));
  assign wr_En = hold_valid_q && aud_out_allowed && (run_play || run_loop);

  assign fifo_full = (count_q == CW'(DEPTH));
  assign cap_pop   = cap_rd && (count_q != '0) && (state_q != S_IDLE);
  assign cap_push  = run_cap && aud_in_av;
  assign push_ok   = cap_push && (!fifo_full || cap_pop);
  assign ovf_set   = cap_push && fifo_full && !cap_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_all) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (cap_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push_ok && !cap_pop) begin
        count_d = count_q + CW'(1);
      end else if (!push_ok && cap_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_l_q[wr_ptr_q] <= codec_left_in;
      fifo_r_q[wr_ptr_q] <= codec_right_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (cap_ovf_clr) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end

  assign play_load = run_play && play_wr && !hold_valid_q;
  assign loop_load = run_loop && aud_in_av && !hold_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
    end else if (clear_all) begin
      hold_valid_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
    end else begin
      if (wr_En) hold_valid_q <= 1'b0;
      if (play_load) begin
        hold_valid_q <= 1'b1;
        hold_l_q     <= play_left;
        hold_r_q     <= play_right;
      end else if (loop_load) begin
        hold_valid_q <= 1'b1;
        hold_l_q     <= codec_left_in;
        hold_r_q     <= codec_right_in;
      end
    end
  end

  assign cap_valid       = (count_q != '0);
  assign cap_left        = cap_valid ? fifo_l_q[rd_ptr_q] : '0;
  assign cap_right       = cap_valid ? fifo_r_q[rd_ptr_q] : '0;
  assign cap_count       = count_q;
  assign cap_ovf         = ovf_q;
  assign codec_left_out  = hold_l_q;
  assign codec_right_out = hold_r_q;
  assign play_busy       = !run_play || hold_valid_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_audio_stream_sched.sv
// Bench for audio_stream_sched: directed mode/flush/overflow/backpressure steps plus randomized
// capture and playback traffic scored against queue-based models.
module tb_audio_stream_sched;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        aud_in_av;
  logic [31:0] codec_left_in, codec_right_in;
  logic        rd_En;
  logic        aud_out_allowed;
  logic        wr_En;
  logic [31:0] codec_left_out, codec_right_out;
  logic        cap_rd;
  logic        cap_valid;
  logic [31:0] cap_left, cap_right;
  logic [2:0]  cap_count;
  logic        cap_ovf;
  logic        cap_ovf_clr;
  logic        play_wr;
  logic [31:0] play_left, play_right;
  logic        play_busy;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  smp_t cap_q[$];
  smp_t pend_q[$];
  logic ovf_exp;

  audio_stream_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .aud_in_av(aud_in_av), .codec_left_in(codec_left_in), .codec_right_in(codec_right_in),
    .rd_En(rd_En), .aud_out_allowed(aud_out_allowed), .wr_En(wr_En),
    .codec_left_out(codec_left_out), .codec_right_out(codec_right_out),
    .cap_rd(cap_rd), .cap_valid(cap_valid), .cap_left(cap_left), .cap_right(cap_right),
    .cap_count(cap_count), .cap_ovf(cap_ovf), .cap_ovf_clr(cap_ovf_clr),
    .play_wr(play_wr), .play_left(play_left), .play_right(play_right),
    .play_busy(play_busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One RUN/capture cycle: check against the sample queue, then apply pop-before-push.
  task automatic cap_cycle(input logic av, input logic rd, input logic clr,
                           input logic [31:0] l, input logic [31:0] r);
    smp_t s, h;
    logic ovf_now;
    aud_in_av = av; cap_rd = rd; cap_ovf_clr = clr;
    codec_left_in = l; codec_right_in = r;
    #1;
    h.l = 32'h0; h.r = 32'h0;
    if (cap_q.size() != 0) h = cap_q[0];
    check("cap_rd_en", 32'(rd_En), 32'(av));
    check("cap_count", 32'(cap_count), 32'(cap_q.size()));
    check("cap_valid", 32'(cap_valid), 32'(cap_q.size() != 0));
    check("cap_left", cap_left, h.l);
    check("cap_right", cap_right, h.r);
    check("cap_ovf", 32'(cap_ovf), 32'(ovf_exp));
    if (rd && cap_q.size() != 0) h = cap_q.pop_front();
    ovf_now = 1'b0;
    if (av) begin
      s.l = l; s.r = r;
      if (cap_q.size() < DEPTH) cap_q.push_back(s);
      else ovf_now = 1'b1;
    end
    ovf_exp = clr ? 1'b0 : (ovf_exp | ovf_now);
    tick();
  endtask

  // One RUN/playback cycle: at most one sample waits for the codec.
  task automatic play_cycle(input logic pw, input logic allowed,
                            input logic [31:0] l, input logic [31:0] r);
    smp_t s, h;
    play_wr = pw; aud_out_allowed = allowed; play_left = l; play_right = r;
    aud_in_av = 1'($urandom);
    #1;
    check("pb_busy", 32'(play_busy), 32'(pend_q.size() != 0));
    check("pb_wr_en", 32'(wr_En), 32'(pend_q.size() != 0 && allowed));
    check("pb_rd_en", 32'(rd_En), 32'h0);
    if (pend_q.size() != 0 && allowed) begin
      h = pend_q.pop_front();
      check("pb_left_out", codec_left_out, h.l);
      check("pb_right_out", codec_right_out, h.r);
    end else if (pw && pend_q.size() == 0) begin
      s.l = l; s.r = r;
      pend_q.push_back(s);
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(rd_En), 32'h0);
    check({tag, "_wr_en"}, 32'(wr_En), 32'h0);
    check({tag, "_cap_valid"}, 32'(cap_valid), 32'h0);
    check({tag, "_cap_ovf"}, 32'(cap_ovf), 32'h0);
    check({tag, "_cap_count"}, 32'(cap_count), 32'h0);
    check({tag, "_left_out"}, codec_left_out, 32'h0);
    check({tag, "_right_out"}, codec_right_out, 32'h0);
    check({tag, "_cap_left"}, cap_left, 32'h0);
    check({tag, "_cap_right"}, cap_right, 32'h0);
    check({tag, "_play_busy"}, 32'(play_busy), 32'h1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; ovf_exp = 1'b0;
    rst = 1'b0; mode = 2'b00; aud_in_av = 1'b0; aud_out_allowed = 1'b0;
    codec_left_in = '0; codec_right_in = '0; cap_rd = 1'b0; cap_ovf_clr = 1'b0;
    play_wr = 1'b0; play_left = '0; play_right = '0;

    // Reset held with random inputs
    tick();
    for (int i = 0; i < 4; i++) begin
      mode = 2'($urandom); aud_in_av = 1'($urandom); aud_out_allowed = 1'($urandom);
      codec_left_in = $urandom; codec_right_in = $urandom; cap_rd = 1'($urandom);
      cap_ovf_clr = 1'($urandom); play_wr = 1'($urandom);
      play_left = $urandom; play_right = $urandom;
      #1;
      check_reset_outputs("reset");
      tick();
    end
    mode = 2'b00; aud_in_av = 1'b0; aud_out_allowed = 1'b0; cap_rd = 1'b0;
    cap_ovf_clr = 1'b0; play_wr = 1'b0;
    rst = 1'b1;
    tick();

    // Flush on entry to capture: three stale samples discarded
    mode = 2'b01; aud_in_av = 1'b1; codec_left_in = $urandom; codec_right_in = $urandom;
    #1;
    check("idle_rd_en", 32'(rd_En), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      codec_left_in = $urandom; codec_right_in = $urandom;
      #1;
      check("flush_rd_en", 32'(rd_En), 32'h1);
      check("flush_cap_count", 32'(cap_count), 32'h0);
      tick();
    end
    aud_in_av = 1'b0;
    #1;
    check("flush_done_rd_en", 32'(rd_En), 32'h0);
    check("flush_cap_valid", 32'(cap_valid), 32'h0);
    tick();

    cap_cycle(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678);
    aud_in_av = 1'b0;
    #1;
    check("first_cap_valid", 32'(cap_valid), 32'h1);
    check("first_cap_left", cap_left, 32'h0000_1234);
    check("first_cap_right", cap_right, 32'h0000_5678);

    // Randomized capture traffic
    for (int i = 0; i < 150; i++) begin
      cap_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                $urandom_range(0, 15) == 0, $urandom, $urandom);
    end

    // Overflow with DEPTH=4
    for (int i = 0; i < DEPTH; i++) cap_cycle(1'b0, 1'b1, 1'b1, $urandom, $urandom);
    for (int i = 0; i < 5; i++) cap_cycle(1'b1, 1'b0, 1'b0, 32'h1000 + i, 32'h2000 + i);
    aud_in_av = 1'b0;
    #1;
    check("ovf_count", 32'(cap_count), 32'd4);
    check("ovf_flag", 32'(cap_ovf), 32'h1);
    check("ovf_head", cap_left, 32'h1000);
    cap_cycle(1'b0, 1'b0, 1'b1, $urandom, $urandom);
    cap_cycle(1'b1, 1'b1, 1'b0, 32'h1005, 32'h2005);
    aud_in_av = 1'b0; cap_rd = 1'b0;
    #1;
    check("full_pushpop_count", 32'(cap_count), 32'd4);
    check("full_pushpop_ovf", 32'(cap_ovf), 32'h0);
    check("full_pushpop_head", cap_left, 32'h1001);

    // Mode switch capture -> playback with two samples queued
    cap_cycle(1'b0, 1'b1, 1'b0, $urandom, $urandom);
    cap_cycle(1'b0, 1'b1, 1'b0, $urandom, $urandom);
    mode = 2'b10; aud_in_av = 1'b0; cap_rd = 1'b0;
    #1;
    check("pre_switch_count", 32'(cap_count), 32'd2);
    tick();
    cap_q.delete();
    aud_in_av = 1'b1;
    #1;
    check("switch_idle_count", 32'(cap_count), 32'h0);
    check("switch_idle_valid", 32'(cap_valid), 32'h0);
    check("switch_idle_rd_en", 32'(rd_En), 32'h0);
    tick();
    #1;
    check("switch_flush_rd_en", 32'(rd_En), 32'h1);
    check("switch_flush_busy", 32'(play_busy), 32'h1);
    aud_in_av = 1'b0;
    #1;
    check("switch_flush_idle_rd_en", 32'(rd_En), 32'h0);
    tick();
    aud_in_av = 1'b1;
    #1;
    check("play_run_rd_en", 32'(rd_En), 32'h0);
    check("play_run_busy", 32'(play_busy), 32'h0);

    // Playback backpressure
    play_cycle(1'b1, 1'b0, 32'hAAAA_0001, 32'hAAAA_0002);
    for (int i = 0; i < 5; i++) begin
      play_cycle(i == 2, 1'b0, 32'hBBBB_0000 + i, 32'hCCCC_0000 + i);
    end
    play_wr = 1'b0;
    #1;
    check("bp_hold_left", codec_left_out, 32'hAAAA_0001);
    play_cycle(1'b0, 1'b1, $urandom, $urandom);
    play_wr = 1'b0;
    #1;
    check("bp_after_busy", 32'(play_busy), 32'h0);
    check("bp_after_wr_en", 32'(wr_En), 32'h0);

    // Randomized playback traffic
    for (int i = 0; i < 80; i++) begin
      play_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, $urandom, $urandom);
    end

    // Mode 11
    mode = 2'b11; play_wr = 1'b0; aud_out_allowed = 1'b1; aud_in_av = 1'b0;
    tick();
`ifdef AUDIO_SCHED_LOOPBACK_EN
    tick();
    tick();
    aud_in_av = 1'b1; codec_left_in = 32'h7FFF_0000; codec_right_in = 32'h0000_8000;
    #1;
    check("loop_rd_en", 32'(rd_En), 32'h1);
    check("loop_wr_en_early", 32'(wr_En), 32'h0);
    tick();
    aud_in_av = 1'b0;
    #1;
    check("loop_wr_en", 32'(wr_En), 32'h1);
    check("loop_left_out", codec_left_out, 32'h7FFF_0000);
    check("loop_right_out", codec_right_out, 32'h0000_8000);
    check("loop_cap_count", 32'(cap_count), 32'h0);
    tick();
    aud_out_allowed = 1'b0; aud_in_av = 1'b1; codec_left_in = 32'h1357_9BDF;
    #1;
    check("loop_wr_en_done", 32'(wr_En), 32'h0);
    check("loop_rd_en_2", 32'(rd_En), 32'h1);
    tick();
    codec_left_in = $urandom;
    #1;
    check("loop_rd_en_held", 32'(rd_En), 32'h0);
    check("loop_wr_en_blocked", 32'(wr_En), 32'h0);
    aud_out_allowed = 1'b1;
    #1;
    check("loop_wr_en_2", 32'(wr_En), 32'h1);
    check("loop_left_out_2", codec_left_out, 32'h1357_9BDF);
    tick();
    #1;
    check("loop_rd_en_resume", 32'(rd_En), 32'h1);
    aud_in_av = 1'b0;
    tick();
`else
    for (int i = 0; i < 4; i++) begin
      aud_in_av = 1'b1; codec_left_in = 32'h7FFF_0000; codec_right_in = 32'h0000_8000;
      #1;
      check("mode11_rd_en", 32'(rd_En), 32'h0);
      check("mode11_wr_en", 32'(wr_En), 32'h0);
      check("mode11_busy", 32'(play_busy), 32'h1);
      tick();
    end
    aud_in_av = 1'b0;
`endif

    // Asynchronous reset in the middle of capture
    mode = 2'b01; aud_in_av = 1'b0; aud_out_allowed = 1'b0;
    tick();
    tick();
    tick();
    cap_q.delete(); ovf_exp = 1'b0;
    for (int i = 0; i < 3; i++) cap_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
    aud_in_av = 1'b1;
    #1;
    check("pre_reset_count", 32'(cap_count), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_stream_sched.md
# audio_stream_sched

Sample-level scheduler between the SoC bus side and the codec wrapper's FIFO handshake (`rd_En`/`aud_in_av` for capture, `wr_En`/`audio_out_allowed` for playback). It drains microphone samples into a small capture FIFO for the CPU and feeds CPU playback samples to the codec. It also sequences mode changes so stale codec data is flushed before a new mode runs. An optional loopback mode routes captured samples straight back to the speaker path.

## Interface
Parameters:
- `DEPTH`, 4 — capture FIFO entries, power of 2, ≥2.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous reset, active-low.
- `mode` in 2 — 00 idle, 01 capture, 10 playback, 11 loopback.
- `aud_in_av` in 1 — codec has an input sample at its FIFO head.
- `codec_left_in`, `codec_right_in` in 32 — codec head sample, valid while `aud_in_av`=1.
- `rd_En` out 1 — pop the codec input FIFO this cycle.
- `aud_out_allowed` in 1 — codec output FIFO has space.
- `wr_En` out 1 — push `codec_left_out`/`codec_right_out` this cycle.
- `codec_left_out`, `codec_right_out` out 32 — playback holding register.
- `cap_rd` in 1 — CPU pops the capture FIFO.
- `cap_valid` out 1 — capture FIFO not empty.
- `cap_left`, `cap_right` out 32 — capture FIFO head.
- `cap_count` out clog2(DEPTH)+1 — capture FIFO occupancy.
- `cap_ovf` out 1 — sticky capture overflow flag.
- `cap_ovf_clr` in 1 — clears `cap_ovf`.
- `play_wr` in 1 — CPU writes `play_left`/`play_right`.
- `play_left`, `play_right` in 32 — playback sample.
- `play_busy` out 1 — `play_wr` is ignored while this is 1.

## Operation
FSM states: IDLE, FLUSH, RUN.
- IDLE: `rd_En`=0, `wr_En`=0. Capture FIFO and holding register are cleared each cycle. Transitions to FLUSH when `mode`≠00.
- FLUSH: `rd_En`=`aud_in_av`; popped data is discarded. Transitions to RUN on the first cycle with `aud_in_av`=0. `mode`=00 returns to IDLE.
- RUN: mode latched on entry as `run_mode`. If `mode`≠`run_mode`, the FSM goes to IDLE for exactly one cycle, then to FLUSH.
- RUN/capture:
  - `rd_En`=`aud_in_av`; the codec is always drained.
  - Each sample is pushed into the capture FIFO.
  - If the FIFO is full and there is no pop in the same cycle, the sample is dropped and `cap_ovf` is set.
  - Push and pop in the same cycle when full: the pop takes effect first, the push succeeds, and there is no overflow.
- RUN/playback:
  - `play_busy`=`hold_valid`.
  - `play_wr` loads the holding register and sets `hold_valid`.
  - `wr_En`=`hold_valid`&`aud_out_allowed`; `hold_valid` clears on the cycle `wr_En`=1.
  - `rd_En`=0.
- RUN/loopback:
  - `rd_En`=`aud_in_av`&~`hold_valid`.
  - A popped sample loads the holding register.
  - `wr_En` is generated as in playback mode.
  - The capture FIFO is untouched.
- `play_busy`=1 whenever the FSM is not in RUN/playback.
- `cap_rd` with the FIFO empty is ignored. `cap_rd` is honoured in any state except IDLE.
- `cap_ovf_clr` takes priority over a same-cycle overflow set.
- Samples pass through unmodified, full 32 bits; no sign or width conversion is applied.

## Timing
- `rd_En` and `wr_En` are combinational from registered state plus `aud_in_av`/`aud_out_allowed`. The codec consumes its head on the same edge, so capture latches `codec_*_in` on that edge.
- Capture latency: `rd_En` in cycle N → `cap_valid`=1 and data on `cap_left`/`cap_right` in cycle N+1.
- Playback: `play_wr` in cycle N → `wr_En` no earlier than N+1. At most one sample per 2 cycles.
- Loopback: `aud_in_av` in cycle N → `wr_En` in N+1 if `aud_out_allowed`=1.
- Reset values:
  - state IDLE.
  - `rd_En`, `wr_En`, `cap_valid`, `cap_ovf` = 0.
  - `cap_count`=0.
  - `codec_left_out`, `codec_right_out`, `cap_left`, `cap_right` = 0.
  - `play_busy`=1.
- Reset asserted mid-operation: all of the above apply immediately. Samples in flight are lost; nothing is replayed.
- FIFO pointers wrap modulo DEPTH. `cap_count` ranges 0..DEPTH.

## Configuration
- `AUDIO_SCHED_LOOPBACK_EN` defined: mode 11 operates as loopback, as specified above.
- `AUDIO_SCHED_LOOPBACK_EN` undefined: loopback logic is removed and `mode`=11 is treated exactly as 00 (the FSM stays in or returns to IDLE).

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs at their reset values, including `play_busy`=1.
- Flush on mode entry: `aud_in_av`=1 for 3 cycles, then `mode`=01 → 3 discarded pops, then RUN. A new sample 0x00001234/0x00005678 then appears on `cap_left`/`cap_right` one cycle after its `rd_En`.
- Overflow, DEPTH=4: push 5 samples with no `cap_rd` → `cap_count`=4, `cap_ovf`=1, head is the first sample. `cap_ovf_clr` → `cap_ovf`=0. Push with simultaneous `cap_rd` while full → `cap_count` stays 4, `cap_ovf` stays 0.
- Playback backpressure: `play_wr` 0xAAAA0001 with `aud_out_allowed`=0 for 5 cycles → `play_busy`=1 and a second `play_wr` is ignored. Raise `aud_out_allowed` → one `wr_En` pulse with 0xAAAA0001, then `play_busy`=0.
- Loopback, with the macro defined: sample 0x7FFF0000 arrives → `wr_En` one cycle later with the same data. With the macro undefined, the same stimulus → `rd_En` and `wr_En` stay 0.
- Mode switch from 01 to 10 with 2 samples in the capture FIFO → one IDLE cycle with `cap_count`=0, then FLUSH, then RUN/playback.
